instr_fetch_queue: RTL and testbench

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

---
 rtl/instr_fetch_queue_pkg.sv | 7 +
 rtl/instr_fetch_queue_if.sv | 28 ++
 rtl/instr_fetch_queue_fifo_mem.sv | 24 ++
 rtl/instr_fetch_queue.sv | 76 +++++++
 tb/tb_instr_fetch_queue.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_queue_pkg.sv
// Shared constants for the instruction fetch queue and the benches that drive it.
package instr_fetch_queue_pkg;

    localparam int unsigned PC_INCR = 4;
    localparam logic [31:0] NOP     = 32'h0000_0013;

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Loader/core handshake bundle; master drives requests, slave is the queue.
interface instr_fetch_queue_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 8
);

    logic                     push_valid;
    logic                     push_ready;
    logic [XLEN-1:0]          push_data;
    logic                     pop_valid;
    logic                     pop_ready;
    logic [XLEN-1:0]          pop_data;
    logic [XLEN-1:0]          pop_pc;
    logic                     flush;
    logic [XLEN-1:0]          flush_pc;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output push_valid, push_data, pop_ready, flush, flush_pc,
        input  push_ready, pop_valid, pop_data, pop_pc, count
    );

    modport slave (
        input  push_valid, push_data, pop_ready, flush, flush_pc,
        output push_ready, pop_valid, pop_data, pop_pc, count
    );

endinterface

// File: rtl/instr_fetch_queue_fifo_mem.sv
// Queue storage: one synchronous write port, one asynchronous read port, no reset.
module fifo_mem #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: tags each pushed word with a running PC and hands
// entries to the core in order; flush redirects the PC and empties the queue.
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 8,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    instr_fetch_queue_if.slave  bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     occ;
    logic [XLEN-1:0]   tail_pc;
    logic              push_fire;
    logic              pop_fire;
    logic              mem_we;
    logic [2*XLEN-1:0] wr_entry;
    logic [2*XLEN-1:0] rd_entry;

    always_comb begin
        bus.push_ready = (occ < CW'(DEPTH));
        bus.pop_valid  = (occ != '0);
        bus.count      = occ;
        push_fire      = bus.push_valid && bus.push_ready;
        pop_fire       = bus.pop_valid && bus.pop_ready;
        mem_we         = push_fire && !bus.flush;
        wr_entry       = {tail_pc, bus.push_data};
        bus.pop_data   = rd_entry[XLEN-1:0];
        bus.pop_pc     = rd_entry[2*XLEN-1:XLEN];
    end

    // Flush wins over any handshake in the same cycle; storage is left untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            occ     <= '0;
            tail_pc <= RESET_PC;
        end else if (bus.flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            occ     <= '0;
            tail_pc <= bus.flush_pc;
        end else begin
            if (push_fire) begin
                wr_ptr  <= wr_ptr + AW'(1);
                tail_pc <= tail_pc + XLEN'(PC_INCR);
            end
            if (pop_fire) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            occ <= occ + CW'(push_fire) - CW'(pop_fire);
        end
    end

    fifo_mem #(
        .WIDTH (2 * XLEN),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomised and directed bench for instr_fetch_queue against a queue-based reference.
module tb_instr_fetch_queue;
    import instr_fetch_queue_pkg::*;

    localparam int unsigned     XLEN     = 32;
    localparam int unsigned     DEPTH    = 8;
    localparam logic [XLEN-1:0] RESET_PC = '0;

    typedef struct {
        logic [XLEN-1:0] data;
        logic [XLEN-1:0] pc;
    } ent_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    ent_t            model[$];
    logic [XLEN-1:0] model_pc;

    instr_fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

    instr_fetch_queue #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Entered and left on a falling edge; compares outputs, then advances the model at the rising edge.
    task automatic cycle(input logic pv, input logic [XLEN-1:0] pd, input logic pr,
                         input logic fl, input logic [XLEN-1:0] fpc);
        bit   push_f;
        bit   pop_f;
        ent_t e;
        bus.push_valid = pv;
        bus.push_data  = pd;
        bus.pop_ready  = pr;
        bus.flush      = fl;
        bus.flush_pc   = fpc;
        #1;
        check("count", 64'(bus.count), 64'(model.size()));
        check("pop_valid", 64'(bus.pop_valid), 64'(model.size() != 0));
        check("push_ready", 64'(bus.push_ready), 64'(model.size() < DEPTH));
        if (model.size() != 0) begin
            check("pop_data", 64'(bus.pop_data), 64'(model[0].data));
            check("pop_pc", 64'(bus.pop_pc), 64'(model[0].pc));
        end
        push_f = pv && (model.size() < DEPTH);
        pop_f  = pr && (model.size() != 0);
        @(posedge clk);
        if (fl) begin
            model.delete();
            model_pc = fpc;
        end else begin
            if (pop_f) void'(model.pop_front());
            if (push_f) begin
                e.data = pd;
                e.pc   = model_pc;
                model.push_back(e);
                model_pc = model_pc + XLEN'(PC_INCR);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        cycle(1'b0, NOP, 1'b0, 1'b0, '0);
    endtask

    // Asynchronous reset asserted between edges with a push offered; nothing may fire.
    task automatic pulse_reset();
        bus.push_valid = 1'b1;
        bus.push_data  = 32'hdead_beef;
        bus.pop_ready  = 1'b1;
        bus.flush      = 1'b0;
        rst = 1'b0;
        #1;
        check("rst_pop_valid", 64'(bus.pop_valid), 64'd0);
        check("rst_count", 64'(bus.count), 64'd0);
        check("rst_push_ready", 64'(bus.push_ready), 64'd1);
        model.delete();
        model_pc = RESET_PC;
        @(posedge clk);
        @(negedge clk);
        check("rst_hold_count", 64'(bus.count), 64'd0);
        rst = 1'b1;
    endtask

    task automatic fill_to(input int n);
        while (model.size() < n) cycle(1'b1, $urandom, 1'b0, 1'b0, '0);
    endtask

    initial begin
        logic [XLEN-1:0] prog [3];
        int              peak;
        errors = 0;
        checks = 0;
        rst = 1'b0;
        bus.push_valid = 1'b0;
        bus.push_data  = NOP;
        bus.pop_ready  = 1'b0;
        bus.flush      = 1'b0;
        bus.flush_pc   = '0;
        model_pc = RESET_PC;
        @(negedge clk);
        @(negedge clk);
        check("reset_count", 64'(bus.count), 64'd0);
        check("reset_pop_valid", 64'(bus.pop_valid), 64'd0);
        check("reset_push_ready", 64'(bus.push_ready), 64'd1);
        rst = 1'b1;

        // Three instructions streamed straight through.
        prog[0] = 32'h0040_0093;
        prog[1] = 32'h0050_0113;
        prog[2] = 32'h4011_0233;
        peak = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, prog[i], 1'b1, 1'b0, '0);
            if (int'(bus.count) > peak) peak = int'(bus.count);
        end
        for (int i = 0; i < 2; i++) cycle(1'b0, NOP, 1'b1, 1'b0, '0);
        check("stream_peak", 64'(peak), 64'd1);

        // Overfill with pop stalled, then drain.
        for (int i = 0; i < 9; i++) cycle(1'b1, 32'h1000 + 32'(i), 1'b0, 1'b0, '0);
        check("full_count", 64'(bus.count), 64'(DEPTH));
        check("full_push_ready", 64'(bus.push_ready), 64'd0);
        for (int i = 0; i < 8; i++) cycle(1'b0, NOP, 1'b1, 1'b0, '0);
        idle();

        // Full queue with push and pop offered together.
        fill_to(DEPTH);
        cycle(1'b1, 32'hcafe_0001, 1'b1, 1'b0, '0);
        check("full_pushpop_count", 64'(bus.count), 64'(DEPTH - 1));
        for (int i = 0; i < 8; i++) cycle(1'b0, NOP, 1'b1, 1'b0, '0);

        // Flush at count 3 with a push offered in the same cycle.
        fill_to(3);
        cycle(1'b1, 32'h5555_5555, 1'b1, 1'b1, 32'h100);
        check("flush_count", 64'(bus.count), 64'd0);
        cycle(1'b1, 32'h0000_0aaa, 1'b0, 1'b0, '0);
        cycle(1'b1, 32'h0000_0bbb, 1'b0, 1'b0, '0);
        check("flush_pc0", 64'(bus.pop_pc), 64'h100);
        cycle(1'b0, NOP, 1'b1, 1'b0, '0);
        check("flush_pc1", 64'(bus.pop_pc), 64'h104);
        cycle(1'b0, NOP, 1'b1, 1'b0, '0);

        // Steady state at count 4 long enough to wrap the pointers.
        fill_to(4);
        for (int i = 0; i < 20; i++) cycle(1'b1, $urandom, 1'b1, 1'b0, '0);
        check("steady_count", 64'(bus.count), 64'd4);

        // Reset mid-stream at count 5.
        fill_to(5);
        pulse_reset();
        cycle(1'b1, 32'h7777_0001, 1'b0, 1'b0, '0);
        check("post_rst_pc", 64'(bus.pop_pc), 64'(RESET_PC));

        // Random traffic with occasional flushes and one reset.
        for (int i = 0; i < 600; i++) begin
            int unsigned pv_bias;
            int unsigned pr_bias;
            pv_bias = (i < 200) ? 80 : (i < 400) ? 30 : 60;
            pr_bias = (i < 200) ? 30 : (i < 400) ? 80 : 60;
            if (i == 450) pulse_reset();
            cycle($urandom_range(0, 99) < pv_bias, $urandom, $urandom_range(0, 99) < pr_bias,
                  $urandom_range(0, 99) < 3, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
